// File: rtl/aia_msi_pkg.sv
// Shared types for the AIA MSI transmit path: FIFO entry, FSM states, IMSIC
// file addressing and the AXI4 master bundle driven toward the interconnect.
package aia_msi_pkg;

  localparam int unsigned AXI_AW = 64;
  localparam int unsigned AXI_DW = 64;
  localparam int unsigned AXI_IW = 10;
  localparam int unsigned AXI_UW = 1;

  localparam logic [31:0] IMSIC_FILE_STRIDE = 32'h1000;
  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B       = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] eiid;
  } msi_entry_t;

  typedef enum logic [1:0] {IDLE, SEND, RESP} msi_tx_state_e;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [AXI_UW-1:0] user;
  } msi_axi_aw_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [AXI_UW-1:0] user;
  } msi_axi_ar_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
    logic [AXI_UW-1:0]   user;
  } msi_axi_w_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
    logic [AXI_UW-1:0] user;
  } msi_axi_b_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [AXI_UW-1:0] user;
  } msi_axi_r_t;

  typedef struct packed {
    msi_axi_aw_t aw;
    logic        aw_valid;
    msi_axi_w_t  w;
    logic        w_valid;
    logic        b_ready;
    msi_axi_ar_t ar;
    logic        ar_valid;
    logic        r_ready;
  } msi_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    msi_axi_b_t b;
    logic       r_valid;
    msi_axi_r_t r;
  } msi_axi_resp_t;

  // M files are one per IMSIC; S/VS files are packed (NR_INTP_FILES-1) per IMSIC.
  function automatic logic [31:0] msi_file_addr(
    input logic        priv,
    input logic [1:0]  hart,
    input logic [5:0]  guest,
    input logic [31:0] m_base,
    input logic [31:0] s_base,
    input int unsigned nr_intp_files
  );
    logic [31:0] idx;
    if (!priv) idx = 32'(hart);
    else       idx = 32'(hart) * (nr_intp_files - 1) + 32'(guest);
    return (priv ? s_base : m_base) + idx * IMSIC_FILE_STRIDE;
  endfunction

endpackage

// File: rtl/msi_tx_fifo.sv
// Request buffer for the MSI transmitter: synchronous FIFO of {addr, eiid}
// with wrap-bit pointers so full and empty are distinguished without a counter.
module msi_tx_fifo
  import aia_msi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       ni_rst,
  input  logic       i_push,
  input  msi_entry_t i_data,
  input  logic       i_pop,
  output msi_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  msi_entry_t     mem_reg [DEPTH];
  logic [PW:0]    wr_ptr_reg, rd_ptr_reg;
  logic           wr_en, rd_en;

  assign o_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign wr_en   = i_push & ~o_full;
  assign rd_en   = i_pop & ~o_empty;

  // Head entry is visible combinationally so the FSM can load it on the pop cycle.
  assign o_data = mem_reg[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_reg[wr_ptr_reg[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/aplic_msi_tx.sv
// MSI transmitter: validates and queues delivery requests, then issues each one
// as a single-beat AXI4 write of the EIID into the target IMSIC file.
module aplic_msi_tx
  import aia_msi_pkg::*;
#(
  parameter int unsigned NR_SRC_LEN            = 32,
  parameter logic [31:0] IMSIC_M_BASE_ADDR     = 32'h2400_0000,
  parameter logic [31:0] IMSIC_S_BASE_ADDR     = 32'h2800_0000,
  parameter int unsigned AXI_ADDR_WIDTH        = 64,
  parameter int unsigned AXI_DATA_WIDTH        = 64,
  parameter int unsigned AXI_ID_WIDTH          = 10,
  parameter int unsigned NR_IMSICS             = 1,
  parameter int unsigned NR_VS_FILES_PER_IMSIC = 0,
  parameter int unsigned NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  parameter int unsigned FIFO_DEPTH            = 4,
  parameter type         axi_req_t             = msi_axi_req_t,
  parameter type         axi_resp_t            = msi_axi_resp_t
) (
  input  logic                  i_clk,
  input  logic                  ni_rst,
  input  logic                  i_msi_valid,
  output logic                  o_msi_ready,
  input  logic                  i_msi_priv,
  input  logic [1:0]            i_msi_hart,
  input  logic [5:0]            i_msi_guest,
  input  logic [NR_SRC_LEN-1:0] i_msi_eiid,
  output axi_req_t              o_req,
  input  axi_resp_t             i_resp,
  output logic                  o_busy,
  output logic                  o_drop,
  output logic                  o_err
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  msi_tx_state_e state_reg, state_next;
  logic          aw_valid_reg, aw_valid_next;
  logic          w_valid_reg, w_valid_next;
  logic [31:0]   aw_addr_reg, aw_addr_next;
  logic [31:0]   w_eiid_reg, w_eiid_next;
  logic          err_reg, err_next;
  logic          drop_reg;
  logic          init_done_reg;

  logic       fifo_full, fifo_empty, push, pop, accept, target_invalid;
  msi_entry_t push_entry, pop_entry;

  assign accept      = i_msi_valid & o_msi_ready;
  assign o_msi_ready = init_done_reg & ~fifo_full;

  assign target_invalid = (32'(i_msi_hart) >= NR_IMSICS) |
                          (~i_msi_priv & (i_msi_guest != '0)) |
                          (i_msi_priv & (32'(i_msi_guest) > NR_VS_FILES_PER_IMSIC));

  // Bad targets are consumed but never reach the queue.
  assign push            = accept & ~target_invalid;
  assign push_entry.addr = msi_file_addr(i_msi_priv, i_msi_hart, i_msi_guest,
                                         IMSIC_M_BASE_ADDR, IMSIC_S_BASE_ADDR,
                                         NR_INTP_FILES);
  assign push_entry.eiid = 32'(i_msi_eiid);

  msi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .ni_rst  (ni_rst),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (pop),
    .o_data  (pop_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_reg     <= IDLE;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      w_eiid_reg    <= '0;
      err_reg       <= 1'b0;
      drop_reg      <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      aw_valid_reg  <= aw_valid_next;
      w_valid_reg   <= w_valid_next;
      aw_addr_reg   <= aw_addr_next;
      w_eiid_reg    <= w_eiid_next;
      err_reg       <= err_next;
      drop_reg      <= accept & target_invalid;
      init_done_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    aw_valid_next = aw_valid_reg;
    w_valid_next  = w_valid_reg;
    aw_addr_next  = aw_addr_reg;
    w_eiid_next   = w_eiid_reg;
    err_next      = 1'b0;
    pop           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          aw_addr_next  = pop_entry.addr;
          w_eiid_next   = pop_entry.eiid;
          aw_valid_next = 1'b1;
          w_valid_next  = 1'b1;
          state_next    = SEND;
        end
      end
      SEND: begin
        // AW and W complete independently; leave once both are done.
        if (aw_valid_reg && i_resp.aw_ready) aw_valid_next = 1'b0;
        if (w_valid_reg && i_resp.w_ready)   w_valid_next  = 1'b0;
        if (!aw_valid_next && !w_valid_next) state_next    = RESP;
      end
      RESP: begin
        if (i_resp.b_valid) begin
          err_next   = (i_resp.b.resp != AXI_RESP_OKAY);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [AXI_ADDR_WIDTH-1:0] aw_addr_ext;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;

  assign aw_addr_ext = AXI_ADDR_WIDTH'(aw_addr_reg);
  assign aw_id       = '0;
  assign w_data      = AXI_DATA_WIDTH'(w_eiid_reg);
  assign w_strb      = STRB_W'(4'hF);

  always_comb begin
    o_req          = '0;
    o_req.aw.id    = aw_id;
    o_req.aw.addr  = aw_addr_ext;
    o_req.aw.size  = AXI_SIZE_4B;
    o_req.aw.burst = AXI_BURST_INCR;
    o_req.aw_valid = aw_valid_reg;
    o_req.w.data   = w_data;
    o_req.w.strb   = w_strb;
    o_req.w.last   = 1'b1;
    o_req.w_valid  = w_valid_reg;
    o_req.b_ready  = (state_reg == RESP);
  end

  assign o_busy = ~fifo_empty | (state_reg != IDLE);
  assign o_drop = drop_reg;
  assign o_err  = err_reg;

  logic unused_resp;
  assign unused_resp = ^{i_resp.ar_ready, i_resp.r_valid, i_resp.r,
                         i_resp.b.id, i_resp.b.user};

endmodule
